// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter producing a registered one-hot grant for a one-hot-select mux.
// Grants are held until ack_i or until the hold watchdog forces a release.
module rr_onehot_arb #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ack_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               timeout_o
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_valid;
  logic               r_timeout;

  logic               w_expire;
  logic [IDX_W-1:0]   w_nextPtr;
  logic [IDX_W-1:0]   w_searchPtr;
  logic [NUM_REQ-1:0] w_cand;
  logic               w_hit;
  logic [IDX_W-1:0]   w_sel;
  logic [NUM_REQ-1:0] w_onehot;

  assign w_expire  = (r_cnt == CNT_W'(MAX_HOLD - 1)) && !ack_i;
  assign w_nextPtr = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

  // On a release edge the search starts past the current grantee and excludes it.
  assign w_searchPtr = (r_state == GRANT) ? w_nextPtr : r_ptr;
  assign w_cand      = (r_state == GRANT) ? (req_i & ~r_gnt) : req_i;

  always_comb begin
    int k;
    k     = 0;
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(w_searchPtr) + i) % NUM_REQ;
      if (!w_hit && w_cand[IDX_W'(k)]) begin
        w_hit = 1'b1;
        w_sel = IDX_W'(k);
      end
    end
  end

  assign w_onehot = NUM_REQ'(1) << w_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_gnt   <= w_onehot;
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (ack_i || w_expire) begin
            r_ptr     <= w_nextPtr;
            r_cnt     <= '0;
            r_timeout <= w_expire;
            if (w_hit) begin
              r_gnt <= w_onehot;
              r_idx <= w_sel;
            end else begin
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = r_valid;
  assign gnt_idx_o   = r_idx;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Self-checking bench for rr_onehot_arb: expected outputs are queued as stimulus
// is driven and compared against the DUT one clock later.
module tb_rr_onehot_arb;

  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] idx;
    logic       to;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic       gntValid;
  logic [1:0] gntIdx;
  logic       timeout;

  int   errors = 0;
  int   checks = 0;
  obs_t sbQ[$];

  rr_onehot_arb #(.NUM_REQ(4), .IDX_W(2), .MAX_HOLD(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (req),
    .ack_i      (ack),
    .gnt_o      (gnt),
    .gnt_valid_o(gntValid),
    .gnt_idx_o  (gntIdx),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  // Reset clears outputs immediately, then idles with no requests for 3 cycles.
  task automatic test_reset();
    obs_t got, want;
    #1;
    sbQ.push_back(8'h00);
    got  = {gnt, gntValid, gntIdx, timeout};
    want = sbQ.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b expected %b", got, want);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = 4'b0000;
      ack = 1'b0;
      sbQ.push_back(8'h00);
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset_idle[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
  endtask

  // Two requesters alternate back-to-back with one ack per grant.
  task automatic test_back_to_back();
    logic [3:0] reqs[5];
    logic       acks[5];
    obs_t       exps[5];
    obs_t       got, want;
    reqs = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
    acks = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exps = '{{4'b0010, 1'b1, 2'd1, 1'b0}, {4'b1000, 1'b1, 2'd3, 1'b0},
             {4'b0010, 1'b1, 2'd1, 1'b0}, {4'b1000, 1'b1, 2'd3, 1'b0},
             {4'b0000, 1'b0, 2'd3, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      ack = acks[i];
      sbQ.push_back(exps[i]);
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
  endtask

  // All four requesting, ack every second cycle: full rotation with wrap.
  task automatic test_rotate();
    logic [3:0] reqs[11];
    logic       acks[11];
    obs_t       exps[11];
    obs_t       got, want;
    reqs = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
             4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    acks = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exps = '{{4'b0001, 1'b1, 2'd0, 1'b0}, {4'b0001, 1'b1, 2'd0, 1'b0},
             {4'b0010, 1'b1, 2'd1, 1'b0}, {4'b0010, 1'b1, 2'd1, 1'b0},
             {4'b0100, 1'b1, 2'd2, 1'b0}, {4'b0100, 1'b1, 2'd2, 1'b0},
             {4'b1000, 1'b1, 2'd3, 1'b0}, {4'b1000, 1'b1, 2'd3, 1'b0},
             {4'b0001, 1'b1, 2'd0, 1'b0}, {4'b0001, 1'b1, 2'd0, 1'b0},
             {4'b0000, 1'b0, 2'd0, 1'b0}};
    for (int i = 0; i < 11; i++) begin
      req = reqs[i];
      ack = acks[i];
      sbQ.push_back(exps[i]);
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL rotate[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
  endtask

  // Sole requester never acks: held 8 cycles, forced release with a timeout pulse, re-granted.
  task automatic test_timeout();
    logic [3:0] reqs[11];
    logic       acks[11];
    obs_t       exps[11];
    obs_t       got, want;
    reqs = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
             4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    acks = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exps = '{{4'b0100, 1'b1, 2'd2, 1'b0}, {4'b0100, 1'b1, 2'd2, 1'b0},
             {4'b0100, 1'b1, 2'd2, 1'b0}, {4'b0100, 1'b1, 2'd2, 1'b0},
             {4'b0100, 1'b1, 2'd2, 1'b0}, {4'b0100, 1'b1, 2'd2, 1'b0},
             {4'b0100, 1'b1, 2'd2, 1'b0}, {4'b0100, 1'b1, 2'd2, 1'b0},
             {4'b0000, 1'b0, 2'd2, 1'b1}, {4'b0100, 1'b1, 2'd2, 1'b0},
             {4'b0000, 1'b0, 2'd2, 1'b0}};
    for (int i = 0; i < 11; i++) begin
      req = reqs[i];
      ack = acks[i];
      sbQ.push_back(exps[i]);
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL timeout[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
  endtask

  // Grantee is masked on its release edge; a lone re-requester waits one idle cycle; idle ack ignored.
  task automatic test_mask();
    logic [3:0] reqs[7];
    logic       acks[7];
    obs_t       exps[7];
    obs_t       got, want;
    reqs = '{4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    acks = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exps = '{{4'b0010, 1'b1, 2'd1, 1'b0}, {4'b0001, 1'b1, 2'd0, 1'b0},
             {4'b0010, 1'b1, 2'd1, 1'b0}, {4'b0000, 1'b0, 2'd1, 1'b0},
             {4'b0010, 1'b1, 2'd1, 1'b0}, {4'b0000, 1'b0, 2'd1, 1'b0},
             {4'b0000, 1'b0, 2'd1, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      req = reqs[i];
      ack = acks[i];
      sbQ.push_back(exps[i]);
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL mask[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
  endtask

  // Grant on 1000 survives its req dropping, then an async reset mid-grant; first grant after uses ptr 0.
  task automatic test_async_reset();
    logic [3:0] reqs[2];
    obs_t       exps[2];
    obs_t       got, want;
    reqs = '{4'b1000, 4'b0000};
    exps = '{{4'b1000, 1'b1, 2'd3, 1'b0}, {4'b1000, 1'b1, 2'd3, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      req = reqs[i];
      ack = 1'b0;
      sbQ.push_back(exps[i]);
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL hold_drop[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
    #2;
    reset_n = 1'b0;
    sbQ.push_back(8'h00);
    #1;
    got  = {gnt, gntValid, gntIdx, timeout};
    want = sbQ.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL midgrant_reset: got %b expected %b", got, want);
    end
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    reset_n = 1'b1;
    sbQ.push_back({4'b0001, 1'b1, 2'd0, 1'b0});
    @(posedge clk); #1;
    got  = {gnt, gntValid, gntIdx, timeout};
    want = sbQ.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL post_reset_grant: got %b expected %b", got, want);
    end
  endtask

  // Ack arriving on the watchdog expiry cycle is a normal release with no timeout pulse.
  task automatic test_ack_on_expiry();
    obs_t got, want;
    for (int i = 0; i < 9; i++) begin
      req = (i == 8) ? 4'b0000 : 4'b1001;
      ack = (i >= 7);
      if (i < 7)       sbQ.push_back({4'b0001, 1'b1, 2'd0, 1'b0});
      else if (i == 7) sbQ.push_back({4'b1000, 1'b1, 2'd3, 1'b0});
      else             sbQ.push_back({4'b0000, 1'b0, 2'd3, 1'b0});
      @(posedge clk); #1;
      got  = {gnt, gntValid, gntIdx, timeout};
      want = sbQ.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL ack_on_expiry[%0d]: got gnt=%b v=%b idx=%0d to=%b expected gnt=%b v=%b idx=%0d to=%b",
                 i, got.gnt, got.valid, got.idx, got.to, want.gnt, want.valid, want.idx, want.to);
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    req     = 4'b0000;
    ack     = 1'b0;
    #1;
    reset_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_rotate();
    test_timeout();
    test_mask();
    test_async_reset();
    test_ack_on_expiry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
